// File: rtl/blake2_msg_ctrl.sv
// blake2_msg_ctrl: frames key/message bytes into 64-byte blake2 core blocks and re-times the digest stream.
// Keyed mode (KEY/KPAD states) is compiled in only when BLAKE2_MSG_CTRL_KEY_EN is defined.
module blake2_msg_ctrl #(
  parameter int BLOCK_BYTES = 64,
  parameter int BB = 128,
  parameter int KW = 7
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           start_i,
  input  logic [KW-1:0]                  kk_i,
  input  logic [KW-1:0]                  nn_i,
  input  logic                           empty_i,
  input  logic                           s_valid_i,
  input  logic [7:0]                     s_data_i,
  input  logic                           s_last_i,
  output logic                           s_ready_o,
  output logic                           core_data_v_o,
  output logic [$clog2(BLOCK_BYTES)-1:0] core_data_idx_o,
  output logic [7:0]                     core_data_o,
  output logic                           core_block_first_o,
  output logic                           core_block_last_o,
  output logic [BB-1:0]                  core_ll_o,
  output logic [KW-1:0]                  core_kk_o,
  output logic [KW-1:0]                  core_nn_o,
  output logic                           core_slow_output_o,
  input  logic                           core_ready_i,
  input  logic                           core_h_v_i,
  input  logic [7:0]                     core_h_i,
  output logic                           dig_valid_o,
  output logic [7:0]                     dig_data_o,
  output logic                           dig_last_o,
  output logic                           busy_o,
  output logic                           done_o
);
  localparam int IW = $clog2(BLOCK_BYTES);
  localparam logic [IW-1:0] LAST = IW'(BLOCK_BYTES - 1);
  localparam logic [KW-1:0] FULL = KW'(BLOCK_BYTES);
`ifdef BLAKE2_MSG_CTRL_KEY_EN
  typedef enum logic [2:0] {IDLE, KEY, KPAD, MSG, PAD, WAIT_H, DIGEST} state_t;
`else
  typedef enum logic [2:0] {IDLE, MSG, PAD, WAIT_H, DIGEST} state_t;
`endif
  state_t state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [BB-1:0] ll_q;
  logic [KW-1:0] kk_q, nn_q, cnt_q, kk_in, nn_in;
  logic first_q, empty_q;
  logic adv, ll_inc, cnt_inc, cnt_clr, dig_fire, dig_end;
`ifdef BLAKE2_MSG_CTRL_KEY_EN
  assign kk_in = kk_i > FULL ? FULL : kk_i;
`else
  logic unused_cfg;
  assign kk_in = '0;
  assign unused_cfg = ^{kk_i, empty_q};
`endif
  assign nn_in = (nn_i == '0 || nn_i > FULL) ? FULL : nn_i;
  assign core_data_idx_o = idx_q;
  assign core_ll_o = ll_q;
  assign core_kk_o = kk_q;
  assign core_nn_o = nn_q;
  assign core_slow_output_o = 1'b0;
  assign busy_o = state_q != IDLE;
  assign done_o = dig_last_o;
  always_comb begin
    state_d = state_q;
    s_ready_o = 1'b0;
    core_data_v_o = 1'b0;
    core_data_o = 8'h0;
    core_block_first_o = 1'b0;
    core_block_last_o = 1'b0;
    adv = 1'b0;
    ll_inc = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    dig_fire = 1'b0;
    dig_end = 1'b0;
    case (state_q)
`ifdef BLAKE2_MSG_CTRL_KEY_EN
      IDLE: if (start_i) state_d = kk_in != '0 ? KEY : empty_i ? PAD : MSG;
      KEY: begin
        s_ready_o = core_ready_i;
        core_data_v_o = s_valid_i & core_ready_i;
        core_data_o = s_data_i;
        core_block_first_o = first_q;
        core_block_last_o = empty_q;
        adv = core_data_v_o;
        ll_inc = core_data_v_o;
        cnt_inc = core_data_v_o;
        cnt_clr = core_data_v_o && cnt_q == kk_q - KW'(1);
        // a key that exactly fills the block closes it without padding
        if (cnt_clr) state_d = idx_q != LAST ? KPAD : empty_q ? WAIT_H : MSG;
      end
      KPAD: begin
        core_data_v_o = core_ready_i;
        core_block_first_o = first_q;
        core_block_last_o = empty_q;
        adv = core_ready_i;
        ll_inc = core_ready_i;
        if (core_ready_i && idx_q == LAST) state_d = empty_q ? WAIT_H : MSG;
      end
`else
      IDLE: if (start_i) state_d = empty_i ? PAD : MSG;
`endif
      MSG: begin
        s_ready_o = core_ready_i;
        core_data_v_o = s_valid_i & core_ready_i;
        core_data_o = s_data_i;
        core_block_first_o = first_q;
        core_block_last_o = s_last_i;
        adv = core_data_v_o;
        ll_inc = core_data_v_o;
        if (core_data_v_o && s_last_i) state_d = idx_q == LAST ? WAIT_H : PAD;
      end
      PAD: begin
        core_data_v_o = core_ready_i;
        core_block_first_o = first_q;
        core_block_last_o = 1'b1;
        adv = core_ready_i;
        if (core_ready_i && idx_q == LAST) state_d = WAIT_H;
      end
      WAIT_H: if (core_h_v_i) state_d = DIGEST;
      DIGEST: begin
        dig_fire = core_h_v_i;
        cnt_inc = core_h_v_i;
        dig_end = core_h_v_i && cnt_q == nn_q - KW'(1);
        if (dig_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      idx_q <= '0;
      ll_q <= '0;
      kk_q <= '0;
      nn_q <= '0;
      cnt_q <= '0;
      first_q <= 1'b0;
      empty_q <= 1'b0;
      dig_valid_o <= 1'b0;
      dig_data_o <= 8'h0;
      dig_last_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        kk_q <= kk_in;
        nn_q <= nn_in;
        empty_q <= empty_i;
        first_q <= 1'b1;
        idx_q <= '0;
        ll_q <= '0;
        cnt_q <= '0;
      end
      if (adv) begin
        idx_q <= idx_q + IW'(1);
        if (idx_q == LAST) first_q <= 1'b0;
      end
      if (ll_inc && !(&ll_q)) ll_q <= ll_q + BB'(1);
      if (cnt_clr) cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + KW'(1);
      dig_valid_o <= dig_fire;
      dig_data_o <= dig_fire ? core_h_i : 8'h0;
      dig_last_o <= dig_end;
    end
  end
endmodule

// File: tb/tb_blake2_msg_ctrl.sv
// tb_blake2_msg_ctrl: randomized bench with a block-level framing model and a cycle-accurate digest schedule.
module tb_blake2_msg_ctrl;
  logic clk = 1'b0, nreset = 1'b0, start_i = 1'b0, empty_i = 1'b0;
  logic [6:0] kk_i = '0, nn_i = '0;
  logic s_valid_i = 1'b0, s_last_i = 1'b0, core_ready_i = 1'b0, core_h_v_i = 1'b0;
  logic [7:0] s_data_i = '0, core_h_i = '0;
  logic s_ready_o, core_data_v_o, core_block_first_o, core_block_last_o, core_slow_output_o;
  logic [5:0] core_data_idx_o;
  logic [7:0] core_data_o, dig_data_o;
  logic [127:0] core_ll_o;
  logic [6:0] core_kk_o, core_nn_o;
  logic dig_valid_o, dig_last_o, busy_o, done_o;

  blake2_msg_ctrl dut (
    .clk(clk), .nreset(nreset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i), .empty_i(empty_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .core_data_v_o(core_data_v_o), .core_data_idx_o(core_data_idx_o), .core_data_o(core_data_o),
    .core_block_first_o(core_block_first_o), .core_block_last_o(core_block_last_o),
    .core_ll_o(core_ll_o), .core_kk_o(core_kk_o), .core_nn_o(core_nn_o),
    .core_slow_output_o(core_slow_output_o), .core_ready_i(core_ready_i), .core_h_v_i(core_h_v_i),
    .core_h_i(core_h_i), .dig_valid_o(dig_valid_o), .dig_data_o(dig_data_o), .dig_last_o(dig_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [5:0] idx; logic [7:0] data; bit first; bit last; bit src; } wr_t;
  typedef struct { int cyc; logic [7:0] data; bit last; } dg_t;
  wr_t wq[$];
  dg_t dq[$];
  logic [7:0] fixed[$];
  int checks = 0, errors = 0;
  int wr_cnt, dig_cnt, done_cnt;
  bit chk_en = 0, busy_exp = 0, ll_fixed = 0, sready_seen;
  logic [127:0] exp_ll, ll_cap;

  function automatic void chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    core_ready_i = $urandom_range(0, 3) != 0;
    s_valid_i = 1'($urandom);
    s_data_i = 8'($urandom);
    s_last_i = 1'($urandom);
  endtask

  task automatic summary_and_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  always @(negedge clk) begin
    bit have, fsrc, ev;
    wr_t w;
    dg_t d;
    if (chk_en) begin
      have = wq.size() != 0;
      fsrc = have ? wq[0].src : 1'b0;
      ev = core_ready_i && have && (!fsrc || s_valid_i);
      chk(s_ready_o == (core_ready_i && fsrc), "s_ready", s_ready_o, core_ready_i && fsrc);
      chk(core_data_v_o == ev, "data_v", core_data_v_o, ev);
      if (core_data_v_o && have) begin
        w = wq.pop_front();
        wr_cnt++;
        chk({core_data_idx_o, core_data_o, core_block_first_o, core_block_last_o} == {w.idx, w.data, w.first, w.last},
            "write", {core_data_idx_o, core_data_o, core_block_first_o, core_block_last_o}, {w.idx, w.data, w.first, w.last});
      end
      if (s_ready_o) sready_seen = 1;
      if (dig_valid_o) dig_cnt++;
      if (done_o) done_cnt++;
      if (dq.size() != 0 && dq[0].cyc == cyc) begin
        d = dq.pop_front();
        chk({dig_valid_o, dig_last_o, done_o, dig_data_o} == {1'b1, d.last, d.last, d.data}, "digest",
            {dig_valid_o, dig_last_o, done_o, dig_data_o}, {1'b1, d.last, d.last, d.data});
      end else
        chk({dig_valid_o, dig_last_o, done_o} == 3'b000, "dig_quiet", {dig_valid_o, dig_last_o, done_o}, 0);
      chk(busy_o == busy_exp, "busy", busy_o, busy_exp);
      chk(core_slow_output_o == 1'b0, "slow", core_slow_output_o, 0);
      if (ll_fixed) chk(core_ll_o == exp_ll, "ll_stable", core_ll_o, exp_ll);
    end
  end

  task automatic run_hash(input int kk, input int nn, input int len, input int stall_at, input int rst_at);
    int kk_e, nn_e, slen, sp, pos, n, stall_left, c;
    logic [7:0] st[$];
    logic [7:0] d[$];
`ifdef BLAKE2_MSG_CTRL_KEY_EN
    kk_e = kk > 64 ? 64 : kk;
`else
    kk_e = 0;
`endif
    nn_e = (nn == 0 || nn > 64) ? 64 : nn;
    for (int i = 0; i < kk_e; i++) st.push_back(8'($urandom));
    for (int i = 0; i < len; i++) st.push_back(fixed.size() == len ? fixed[i] : 8'($urandom));
    slen = st.size();
    wr_cnt = 0; dig_cnt = 0; done_cnt = 0; sready_seen = 0;
    start_i = 1; kk_i = 7'(kk); nn_i = 7'(nn); empty_i = len == 0;
    s_valid_i = 0; core_ready_i = 1'($urandom); core_h_v_i = 0;
    tick();
    start_i = 0;
    pos = 0;
    if (kk_e > 0) begin
      for (int i = 0; i < 64; i++) wq.push_back('{6'(i), i < kk_e ? st[i] : 8'h0, 1'b1, len == 0, i < kk_e});
      pos = 64;
    end
    for (int i = 0; i < len; i++) begin
      wq.push_back('{6'(pos), st[kk_e + i], pos < 64, i == len - 1, 1'b1});
      pos++;
    end
    if (len > 0)
      while (pos % 64 != 0) begin
        wq.push_back('{6'(pos), 8'h0, pos < 64, 1'b1, 1'b0});
        pos++;
      end
    if (kk_e == 0 && len == 0)
      for (int i = 0; i < 64; i++) wq.push_back('{6'(i), 8'h0, 1'b1, 1'b1, 1'b0});
    exp_ll = 128'(kk_e > 0 ? 64 + len : len);
    busy_exp = 1;
    sp = 0; n = 0; stall_left = 5;
    while (wq.size() != 0) begin
      if (++n > 4000) begin
        chk(0, "write_timeout", wq.size(), 0);
        summary_and_stop();
      end
      if (stall_at >= 0 && sp == stall_at && stall_left > 0) begin
        core_ready_i = 0;
        stall_left--;
      end else core_ready_i = $urandom_range(0, 7) != 0;
      s_valid_i = sp < slen && $urandom_range(0, 3) != 0;
      s_data_i = sp < slen ? st[sp] : 8'($urandom);
      s_last_i = len > 0 && sp == slen - 1;
      start_i = $urandom_range(0, 40) == 0;
      kk_i = 7'($urandom); nn_i = 7'($urandom); empty_i = 1'($urandom);
      @(negedge clk);
      if (s_valid_i && s_ready_o) sp++;
      tick();
    end
    start_i = 0;
    ll_fixed = 1;
    ll_cap = core_ll_o;
    chk(core_ll_o == exp_ll, "ll_end", core_ll_o, exp_ll);
    chk(core_kk_o == 7'(kk_e), "kk_cfg", core_kk_o, kk_e);
    chk(core_nn_o == 7'(nn_e), "nn_cfg", core_nn_o, nn_e);
    repeat ($urandom_range(0, 3)) begin
      junk();
      tick();
    end
    junk();
    core_h_v_i = 1;
    core_h_i = 8'($urandom);
    c = cyc;
    for (int k = 0; k < nn_e; k++) begin
      d.push_back(8'($urandom));
      if (rst_at < 0 || k < rst_at) dq.push_back('{c + 2 + k, d[k], k == nn_e - 1});
    end
    for (int k = 0; k < nn_e; k++) begin
      tick();
      junk();
      core_h_i = d[k];
      if (k == rst_at) begin
        nreset = 0;
        break;
      end
    end
    tick();
    junk();
    core_h_v_i = 0; nreset = 1; busy_exp = 0; ll_fixed = 0;
    wq.delete();
    repeat (2) tick();
    chk(dq.size() == 0, "dig_pending", dq.size(), 0);
    dq.delete();
  endtask

  initial begin
    #500000;
    chk(0, "watchdog", cyc, 0);
    summary_and_stop();
  end

  initial begin
    nreset = 0; start_i = 1; kk_i = 7'd5; nn_i = 7'd9; s_valid_i = 1; s_data_i = 8'hA5; core_ready_i = 1; core_h_v_i = 1;
    repeat (2) tick();
    @(negedge clk);
    chk({s_ready_o, core_data_v_o, core_block_first_o, core_block_last_o, core_slow_output_o,
         dig_valid_o, dig_last_o, busy_o, done_o} == 9'b0, "reset_flags",
        {s_ready_o, core_data_v_o, core_block_first_o, core_block_last_o, core_slow_output_o,
         dig_valid_o, dig_last_o, busy_o, done_o}, 0);
    chk({core_data_idx_o, core_data_o, dig_data_o} == 22'b0, "reset_data", {core_data_idx_o, core_data_o, dig_data_o}, 0);
    chk(core_ll_o == 128'b0, "reset_ll", core_ll_o, 0);
    chk({core_kk_o, core_nn_o} == 14'b0, "reset_cfg", {core_kk_o, core_nn_o}, 0);
    tick();
    nreset = 1; start_i = 0; s_valid_i = 0; core_h_v_i = 0;
    chk_en = 1;
    tick();
    fixed = '{8'h61, 8'h62, 8'h63};
    run_hash(0, 64, 3, -1, -1);
    fixed.delete();
    chk(ll_cap == 128'd3, "abc_ll", ll_cap, 3);
    chk(wr_cnt == 64, "abc_writes", wr_cnt, 64);
    chk(dig_cnt == 64, "abc_digest_len", dig_cnt, 64);
    chk(done_cnt == 1, "abc_done_once", done_cnt, 1);
    run_hash(0, 32, 0, -1, -1);
    chk(ll_cap == 128'd0, "empty_ll", ll_cap, 0);
    chk(wr_cnt == 64, "empty_writes", wr_cnt, 64);
    chk(dig_cnt == 32, "empty_digest_len", dig_cnt, 32);
    chk(sready_seen == 0, "empty_no_ready", sready_seen, 0);
    run_hash(0, 64, 128, -1, -1);
    chk(ll_cap == 128'd128, "m128_ll", ll_cap, 128);
    chk(wr_cnt == 128, "m128_writes", wr_cnt, 128);
    run_hash(32, 64, 1, -1, -1);
`ifdef BLAKE2_MSG_CTRL_KEY_EN
    chk(ll_cap == 128'd65, "keyed_ll", ll_cap, 65);
    chk(wr_cnt == 128, "keyed_writes", wr_cnt, 128);
`else
    chk(ll_cap == 128'd1, "unkeyed_ll", ll_cap, 1);
    chk(wr_cnt == 64, "unkeyed_writes", wr_cnt, 64);
`endif
    run_hash(0, 64, 40, 20, -1);
    chk(ll_cap == 128'd40, "stall_ll", ll_cap, 40);
    run_hash(0, 32, 10, -1, 10);
    chk(dig_cnt == 10, "rst_digest_cut", dig_cnt, 10);
    chk(done_cnt == 0, "rst_no_done", done_cnt, 0);
    run_hash(0, 16, 5, -1, -1);
    chk(dig_cnt == 16, "post_rst_digest", dig_cnt, 16);
    chk(done_cnt == 1, "post_rst_done", done_cnt, 1);
    run_hash(70, 0, 64, -1, -1);
    chk(dig_cnt == 64, "nn0_as_64", dig_cnt, 64);
    for (int t = 0; t < 10; t++) begin
      int l;
      l = $urandom_range(0, 3) == 0 ? 64 * $urandom_range(0, 2) : $urandom_range(1, 150);
      run_hash($urandom_range(0, 70), $urandom_range(0, 90), l, $urandom_range(0, 1) ? $urandom_range(0, 30) : -1, -1);
    end
    summary_and_stop();
  end
endmodule
